// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite responder for a word-organised SRAM with wait states and ERROR response
// Optional feature macro: AHB_SRAM_RANGE_CHECK_EN (reject accesses above the SRAM depth)
module ahb_sram_slave #(
    parameter int MEM_AW      = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [1:0]  HTRANS,
    input  logic        HMASTLOCK,
    input  logic [31:0] HWDATA,
    input  logic        HREADYIN,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP
);
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LAST, S_ERR1, S_ERR2} state_t;

    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [MEM_AW-1:0] idx_q, idx_d;
    logic [3:0]        be_q, be_d;
    logic              write_q, write_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       mem [2**MEM_AW];

    logic              ready_int;
    logic              accept;
    logic              illegal;
    logic              commit;
    logic              rd_load;
    logic [3:0]        be_new;
    logic [31:0]       rd_word;
    logic              unused_ok;

    assign unused_ok = ^{HBURST, HMASTLOCK, HTRANS[0], HADDR[31:MEM_AW+2]};

    // A new address phase can only be taken while this slave is not stalling the bus.
    assign ready_int = (state_q == S_IDLE) || (state_q == S_LAST) || (state_q == S_ERR2);
    assign accept    = HSEL && HREADYIN && HTRANS[1] && ready_int;
    assign commit    = (state_q == S_LAST) && write_q;

    always_comb begin
        be_new = 4'b0000;
        case (HSIZE)
            3'b000:  be_new = 4'b0001 << HADDR[1:0];
            3'b001:  be_new = HADDR[1] ? 4'b1100 : 4'b0011;
            default: be_new = 4'b1111;
        endcase
    end

    always_comb begin
        illegal = (HSIZE > 3'b010)
               || ((HSIZE == 3'b001) && HADDR[0])
               || ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));
`ifdef AHB_SRAM_RANGE_CHECK_EN
        if (HADDR[31:MEM_AW+2] != '0) begin
            illegal = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        be_d      = be_q;
        write_d   = write_q;
        HREADYOUT = 1'b1;
        HRESP     = 2'b00;
        case (state_q)
            S_WAIT: begin
                HREADYOUT = 1'b0;
                if (cnt_q == 4'd0) begin
                    state_d = S_LAST;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 2'b01;
                state_d   = S_ERR2;
            end
            S_ERR2: begin
                HRESP   = 2'b01;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            idx_d   = HADDR[MEM_AW+1:2];
            be_d    = be_new;
            write_d = HWRITE && !illegal;
            if (illegal) begin
                state_d = S_ERR1;
            end else if (WAIT_STATES > 0) begin
                state_d = S_WAIT;
                cnt_d   = WS_LOAD;
            end else begin
                state_d = S_LAST;
            end
        end
    end

    // Read is sampled on the edge entering LAST; a write committing on that same edge is merged in.
    assign rd_load = (state_d == S_LAST) && !write_d;

    always_comb begin
        rd_word = mem[idx_d];
        if (commit && (idx_q == idx_d)) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    rd_word[8*b +: 8] = HWDATA[8*b +: 8];
                end
            end
        end
        rdata_d = rd_load ? rd_word : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            be_q    <= 4'b0000;
            write_q <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            be_q    <= be_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
        end
    end

    assign HRDATA = rdata_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - self-checking bench for ahb_sram_slave (WAIT_STATES=1 and WAIT_STATES=0 instances)
module tb_ahb_sram_slave;

`ifdef AHB_SRAM_RANGE_CHECK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsel_bus;
    logic        sel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [1:0]  htrans;
    logic        hmastlock;
    logic [31:0] hwdata;
    logic [31:0] hrdata0, hrdata1;
    logic        hro0, hro1;
    logic [1:0]  hresp0, hresp1;

    int errors = 0;
    int checks = 0;

    logic [31:0] ref_mem [0:1][0:15];

    always #5 clk = ~clk;

    ahb_sram_slave #(.MEM_AW(10), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .HSEL(hsel_bus & ~sel), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HMASTLOCK(hmastlock), .HWDATA(hwdata),
        .HREADYIN(hro0), .HRDATA(hrdata0), .HREADYOUT(hro0), .HRESP(hresp0)
    );

    ahb_sram_slave #(.MEM_AW(10), .WAIT_STATES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .HSEL(hsel_bus & sel), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HMASTLOCK(hmastlock), .HWDATA(hwdata),
        .HREADYIN(hro1), .HRDATA(hrdata1), .HREADYOUT(hro1), .HRESP(hresp1)
    );

    typedef struct {
        logic        s;
        logic        w;
        logic [31:0] a;
        logic [2:0]  sz;
        logic [31:0] wd;
        logic [1:0]  er;
        logic        chk;
        logic [31:0] erd;
    } vec_t;

    vec_t tbl[$];

    function automatic logic cur_ready();
        return sel ? hro1 : hro0;
    endfunction

    function automatic logic [1:0] cur_resp();
        return sel ? hresp1 : hresp0;
    endfunction

    function automatic logic [31:0] cur_rdata();
        return sel ? hrdata1 : hrdata0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic s, input logic w, input logic [31:0] a, input logic [2:0] sz,
                           input logic [31:0] wd, input logic [1:0] er, input logic c, input logic [31:0] erd);
        vec_t v;
        v.s = s; v.w = w; v.a = a; v.sz = sz; v.wd = wd; v.er = er; v.chk = c; v.erd = erd;
        tbl.push_back(v);
    endtask

    task automatic idle();
        hsel_bus = 1'($urandom);
        htrans   = 2'($urandom_range(0, 1));
        haddr    = $urandom;
        @(negedge clk);
        htrans   = 2'b00;
    endtask

    // Starts at a negedge; returns at the negedge of the final data cycle so the caller may pipeline.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd,
                        output logic [31:0] rd, output logic [1:0] resp, output logic [1:0] resp0,
                        output int waits);
        hsel_bus  = 1'b1;
        htrans    = 2'b10;
        haddr     = a;
        hwrite    = w;
        hsize     = sz;
        hburst    = 3'($urandom);
        hmastlock = 1'($urandom);
        @(negedge clk);
        htrans    = 2'b00;
        hsel_bus  = 1'($urandom);
        haddr     = $urandom;
        hwrite    = 1'($urandom);
        hsize     = 3'($urandom);
        hwdata    = wd;
        waits     = 0;
        resp0     = cur_resp();
        while (!cur_ready() && waits < 40) begin
            waits++;
            @(negedge clk);
        end
        resp = cur_resp();
        rd   = cur_rdata();
        checks++;
        if (waits >= 40) begin
            errors++;
            $display("FAIL timeout: waited %0d cycles, limit 40", waits);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  resp, resp0;
        int          waits, ws;
        logic        w, legal;
        logic [31:0] a, wd;
        logic [2:0]  sz;
        int          idx, nb, lane, r;

        rst_n = 1'b0; sel = 1'b1; hsel_bus = 1'b0; haddr = 32'h0; hwrite = 1'b0; hsize = 3'b010;
        hburst = 3'b000; htrans = 2'b00; hmastlock = 1'b0; hwdata = 32'h0;

        add_vec(1, 1, 32'h10,   3'b010, 32'hDEADBEEF, 2'b00, 0, 32'h0);
        add_vec(1, 0, 32'h10,   3'b010, 32'h0,        2'b00, 1, 32'hDEADBEEF);
        add_vec(1, 1, 32'h10,   3'b010, 32'h11223344, 2'b00, 0, 32'h0);
        add_vec(1, 1, 32'h13,   3'b000, 32'hA5A5A5A5, 2'b00, 0, 32'h0);
        add_vec(1, 0, 32'h10,   3'b010, 32'h0,        2'b00, 1, 32'hA5223344);
        add_vec(1, 1, 32'h10,   3'b010, 32'h11223344, 2'b00, 0, 32'h0);
        add_vec(1, 1, 32'h12,   3'b001, 32'hBEEFBEEF, 2'b00, 0, 32'h0);
        add_vec(1, 0, 32'h10,   3'b010, 32'h0,        2'b00, 1, 32'hBEEF3344);
        add_vec(1, 1, 32'h00,   3'b010, 32'hCAFEF00D, 2'b00, 0, 32'h0);
        add_vec(1, 0, 32'h02,   3'b010, 32'h0,        2'b01, 0, 32'h0);
        add_vec(1, 1, 32'h02,   3'b010, 32'hFFFFFFFF, 2'b01, 0, 32'h0);
        add_vec(1, 0, 32'h00,   3'b010, 32'h0,        2'b00, 1, 32'hCAFEF00D);
        add_vec(1, 1, 32'h11,   3'b001, 32'hFFFFFFFF, 2'b01, 0, 32'h0);
        add_vec(1, 1, 32'h10,   3'b011, 32'hFFFFFFFF, 2'b01, 0, 32'h0);
        add_vec(1, 0, 32'h10,   3'b010, 32'h0,        2'b00, 1, 32'hBEEF3344);
        add_vec(1, 0, 32'h1000, 3'b010, 32'h0, RANGE_CHK ? 2'b01 : 2'b00, !RANGE_CHK, 32'hCAFEF00D);
        add_vec(0, 1, 32'h20,   3'b010, 32'h12345678, 2'b00, 0, 32'h0);
        add_vec(0, 0, 32'h20,   3'b010, 32'h0,        2'b00, 1, 32'h12345678);
        add_vec(0, 1, 32'h20,   3'b010, 32'h11223344, 2'b00, 0, 32'h0);
        add_vec(0, 1, 32'h21,   3'b000, 32'h5A5A5A5A, 2'b00, 0, 32'h0);
        add_vec(0, 0, 32'h20,   3'b010, 32'h0,        2'b00, 1, 32'h11225A44);
        add_vec(0, 1, 32'h22,   3'b001, 32'hABCDABCD, 2'b00, 0, 32'h0);
        add_vec(0, 0, 32'h20,   3'b010, 32'h0,        2'b00, 1, 32'hABCD5A44);
        add_vec(0, 0, 32'h21,   3'b010, 32'h0,        2'b01, 0, 32'h0);

        repeat (3) @(negedge clk);
        chk("reset_hready1", 32'(hro1), 32'h1);
        chk("reset_hresp1", 32'(hresp1), 32'h0);
        chk("reset_hrdata1", hrdata1, 32'h0);
        chk("reset_hready0", 32'(hro0), 32'h1);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            if (tbl[i].s != sel) begin
                idle();
                sel = tbl[i].s;
            end
            ws = (tbl[i].er == 2'b01) ? 1 : (tbl[i].s ? 1 : 0);
            xfer(tbl[i].w, tbl[i].a, tbl[i].sz, tbl[i].wd, rd, resp, resp0, waits);
            chk($sformatf("vec%0d_waits", i), 32'(waits), 32'(ws));
            chk($sformatf("vec%0d_resp_first", i), 32'(resp0), 32'(tbl[i].er));
            chk($sformatf("vec%0d_resp_last", i), 32'(resp), 32'(tbl[i].er));
            if (tbl[i].chk) chk($sformatf("vec%0d_rdata", i), rd, tbl[i].erd);
            if (tbl[i].er == 2'b01) chk($sformatf("vec%0d_err_rdata", i), rd, 32'h0);
        end

        // Reset in the middle of a write wait state must drop the write.
        idle();
        sel = 1'b1;
        idle();
        hsel_bus = 1'b1; htrans = 2'b10; haddr = 32'h10; hwrite = 1'b1; hsize = 3'b010;
        @(negedge clk);
        htrans = 2'b00; hwdata = 32'h0BADF00D;
        chk("rst_pre_wait_hready", 32'(hro1), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_hready", 32'(hro1), 32'h1);
        chk("rst_async_hresp", 32'(hresp1), 32'h0);
        chk("rst_async_hrdata", hrdata1, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        xfer(1'b0, 32'h10, 3'b010, 32'h0, rd, resp, resp0, waits);
        chk("rst_dropped_write", rd, 32'hBEEF3344);
        chk("rst_dropped_resp", 32'(resp), 32'h0);

        // Randomized traffic against a byte-lane memory model.
        for (int s = 0; s < 2; s++) begin
            idle();
            sel = s[0];
            idle();
            for (int k = 0; k < 16; k++) begin
                wd = $urandom;
                xfer(1'b1, 32'(k) << 2, 3'b010, wd, rd, resp, resp0, waits);
                ref_mem[s][k] = wd;
            end
            for (int n = 0; n < 150; n++) begin
                r = $urandom_range(0, 9);
                if (r == 0) begin
                    idle();
                end else begin
                    w   = 1'($urandom);
                    idx = $urandom_range(0, 15);
                    a   = (32'(idx) << 2) | 32'($urandom_range(0, 3));
                    if ($urandom_range(0, 7) == 0) a[31:12] = 20'($urandom);
                    r   = $urandom_range(0, 9);
                    sz  = (r < 9) ? 3'(r % 3) : 3'($urandom_range(3, 7));
                    wd  = $urandom;
                    legal = (sz <= 3'd2) && ((a % (32'd1 << sz)) == 0) && !(RANGE_CHK && a[31:12] != 20'd0);
                    xfer(w, a, sz, wd, rd, resp, resp0, waits);
                    chk($sformatf("rnd%0d_%0d_resp", s, n), 32'(resp), legal ? 32'h0 : 32'h1);
                    chk($sformatf("rnd%0d_%0d_waits", s, n), 32'(waits), legal ? 32'(s) : 32'h1);
                    if (!legal) begin
                        chk($sformatf("rnd%0d_%0d_err_rdata", s, n), rd, 32'h0);
                    end else if (!w) begin
                        chk($sformatf("rnd%0d_%0d_rdata", s, n), rd, ref_mem[s][idx]);
                    end else begin
                        nb = 1 << sz;
                        for (int b = 0; b < nb; b++) begin
                            lane = int'(a[1:0]) + b;
                            ref_mem[s][idx][8*lane +: 8] = wd[8*lane +: 8];
                        end
                    end
                end
            end
        end
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
